// File: rtl/gen_pad_pkg.sv
// Shared types and bit maps for the Genesis pad host: FSM states, phase indices,
// button snapshot layout and raw pad line positions.
package gen_pad_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_PHASE, ST_GAP} state_t;

  localparam int PHASE_W = 3;
  localparam logic [PHASE_W-1:0] PH_BASIC   = 3'd0;
  localparam logic [PHASE_W-1:0] PH_PRESENT = 3'd1;
  localparam logic [PHASE_W-1:0] PH_SIXID   = 3'd5;
  localparam logic [PHASE_W-1:0] PH_EXT     = 3'd6;
  localparam logic [PHASE_W-1:0] PH_CONFIRM = 3'd7;

  localparam int BTN_W     = 12;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

  localparam int PAD_W  = 6;
  localparam int PIN_D0 = 0;
  localparam int PIN_D1 = 1;
  localparam int PIN_D2 = 2;
  localparam int PIN_D3 = 3;
  localparam int PIN_TL = 4;
  localparam int PIN_TR = 5;

endpackage

// File: rtl/gen_pad_host_sync.sv
// Two-flop synchronizer for the asynchronous pad lines; resets to all-ones,
// which is the idle (nothing pressed / unplugged) level of the pad.
module pad_sync #(
  parameter int W = 6
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gen_pad_host.sv
// Genesis 3/6-button pad initiator: walks TH through the 8-phase select sequence,
// samples the pad lines and commits one atomic button snapshot per poll.
//
//  state    | meaning
//  ST_IDLE  | TH high, waiting for a POLL on a CE tick
//  ST_PHASE | TH driven per phase index, SETTLE CE ticks then sample
//  ST_GAP   | TH high for GAP CE ticks so the pad's 6-button counter times out
module gen_pad_host
  import gen_pad_pkg::*;
#(
  parameter int SETTLE = 8,
  parameter int GAP    = 2000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             POLL,
  input  logic             FORCE3,
  input  logic [PAD_W-1:0] PAD_IN,
  output logic             PAD_TH,
  output logic [BTN_W-1:0] BTN,
  output logic             PRESENT,
  output logic             SIX,
  output logic             VALID,
  output logic             BUSY
);

  localparam int CW = $clog2(((GAP > SETTLE) ? GAP : SETTLE) + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP - 1);

  logic [PAD_W-1:0] pad_s;
  logic [PAD_W-1:0] pr;

  pad_sync #(.W(PAD_W)) u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (PAD_IN),
    .q     (pad_s)
  );

  // 1 = line pulled low = pressed
  assign pr = ~pad_s;

  state_t             state, state_n;
  logic [PHASE_W-1:0] idx, idx_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               th, th_n;
  logic               forced3, forced3_n;
  logic [BTN_W-1:0]   btn_tmp, btn_tmp_n;
  logic               present_tmp, present_tmp_n;
  logic               six_tmp, six_tmp_n;
  logic [BTN_W-1:0]   btn_q, btn_n;
  logic               present_q, present_n;
  logic               six_q, six_n;
  logic               valid_q, valid_n;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      idx         <= '0;
      cnt         <= '0;
      th          <= 1'b1;
      forced3     <= 1'b0;
      btn_tmp     <= '0;
      present_tmp <= 1'b0;
      six_tmp     <= 1'b0;
      btn_q       <= '0;
      present_q   <= 1'b0;
      six_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      th          <= th_n;
      forced3     <= forced3_n;
      btn_tmp     <= btn_tmp_n;
      present_tmp <= present_tmp_n;
      six_tmp     <= six_tmp_n;
      btn_q       <= btn_n;
      present_q   <= present_n;
      six_q       <= six_n;
      valid_q     <= valid_n;
    end
  end

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    cnt_n         = cnt;
    th_n          = th;
    forced3_n     = forced3;
    btn_tmp_n     = btn_tmp;
    present_tmp_n = present_tmp;
    six_tmp_n     = six_tmp;
    btn_n         = btn_q;
    present_n     = present_q;
    six_n         = six_q;
    valid_n       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (CE && POLL) begin
          state_n       = ST_PHASE;
          idx_n         = '0;
          cnt_n         = '0;
          th_n          = 1'b1;
          forced3_n     = FORCE3;
          btn_tmp_n     = '0;
          present_tmp_n = 1'b0;
          six_tmp_n     = 1'b0;
        end
      end

      ST_PHASE: begin
        if (CE) begin
          if (cnt == SETTLE_LAST) begin
            cnt_n = '0;
            case (idx)
              PH_BASIC: begin
                btn_tmp_n[BTN_UP]    = pr[PIN_D0];
                btn_tmp_n[BTN_DOWN]  = pr[PIN_D1];
                btn_tmp_n[BTN_LEFT]  = pr[PIN_D2];
                btn_tmp_n[BTN_RIGHT] = pr[PIN_D3];
                btn_tmp_n[BTN_B]     = pr[PIN_TL];
                btn_tmp_n[BTN_C]     = pr[PIN_TR];
              end
              PH_PRESENT: begin
                present_tmp_n        = pr[PIN_D2] & pr[PIN_D3];
                btn_tmp_n[BTN_A]     = pr[PIN_TL];
                btn_tmp_n[BTN_START] = pr[PIN_TR];
              end
              PH_SIXID: six_tmp_n = &pr[PIN_D3:PIN_D0];
              PH_EXT: begin
                btn_tmp_n[BTN_Z]    = pr[PIN_D0];
                btn_tmp_n[BTN_Y]    = pr[PIN_D1];
                btn_tmp_n[BTN_X]    = pr[PIN_D2];
                btn_tmp_n[BTN_MODE] = pr[PIN_D3];
              end
              PH_CONFIRM: six_tmp_n = six_tmp & ~(|pr[PIN_D3:PIN_D0]);
              default: ;
            endcase

            if (idx == PH_CONFIRM || (forced3 && idx == PH_PRESENT)) begin
              // commit from the _n values so the final sample lands in this snapshot
              state_n   = ST_GAP;
              th_n      = 1'b1;
              valid_n   = 1'b1;
              present_n = present_tmp_n;
              six_n     = present_tmp_n & six_tmp_n & ~forced3;
              btn_n     = btn_tmp_n;
              if (!six_n)         btn_n[BTN_MODE:BTN_Z] = '0;
              if (!present_tmp_n) btn_n = '0;
            end else begin
              idx_n = idx + PHASE_W'(1);
              th_n  = idx[0];
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end

      ST_GAP: begin
        if (CE) begin
          if (cnt == GAP_LAST) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign PAD_TH  = th;
  assign BTN     = btn_q;
  assign PRESENT = present_q;
  assign SIX     = six_q;
  assign VALID   = valid_q;
  assign BUSY    = (state != ST_IDLE);

endmodule

// File: tb/tb_gen_pad_host.sv
// Bench for gen_pad_host: behavioural 3/6-button pad on the TH line, outcome
// model per pad type, CE-counted latency/BUSY checks and randomized polls.
module tb_gen_pad_host;

  localparam int SETTLE = 8;
  localparam int GAP    = 2000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CE = 1'b0;
  logic        POLL = 1'b0;
  logic        FORCE3 = 1'b0;
  logic [5:0]  PAD_IN;
  logic        PAD_TH;
  logic [11:0] BTN;
  logic        PRESENT, SIX, VALID, BUSY;

  int vectors = 0;
  int miscompares = 0;

  int          ptype = 0;      // 0 none, 1 three-button, 2 six-button
  logic [11:0] pbtn = '0;      // pressed buttons, BTN bit layout
  int          falls = 0;
  int          fall_base = 0;
  int          ce_per = 4;
  bit          ce_rand = 0;
  int          ce_div = 0;
  int          ce_cnt = 0;

  gen_pad_host #(.SETTLE(SETTLE), .GAP(GAP)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .POLL(POLL), .FORCE3(FORCE3),
    .PAD_IN(PAD_IN), .PAD_TH(PAD_TH), .BTN(BTN), .PRESENT(PRESENT),
    .SIX(SIX), .VALID(VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (ce_rand) CE = ($urandom_range(0, 1) == 1);
    else begin
      ce_div++;
      if (ce_div >= ce_per) ce_div = 0;
      CE = (ce_div == 0);
    end
  end

  always @(posedge CLK) if (CE && !RESET) ce_cnt++;
  always @(negedge PAD_TH) falls++;

  // Real pad: TH falling-edge count selects the extended 6-button cycles.
  function automatic logic [5:0] pad_drive(int t, logic [11:0] b, logic th, int f);
    logic [5:0] p;
    if (t == 0) return 6'h3F;
    if (t == 2 && !th && f == 3)      p = {b[7], b[4], 4'b1111};
    else if (t == 2 && th && f == 3)  p = {b[6], b[5], b[11], b[10], b[9], b[8]};
    else if (t == 2 && !th && f == 4) p = {b[7], b[4], 4'b0000};
    else if (th)                      p = {b[6], b[5], b[3], b[2], b[1], b[0]};
    else                              p = {b[7], b[4], 2'b11, b[1], b[0]};
    return ~p;
  endfunction

  assign PAD_IN = pad_drive(ptype, pbtn, PAD_TH, falls - fall_base);

  // Expected {PRESENT, SIX, BTN} from what a poll of this pad should report.
  function automatic logic [13:0] model(int t, logic [11:0] b, logic f3);
    if (t == 0) return 14'h0;
    if (t == 1 || f3) return {2'b10, 4'h0, b[7:0]};
    return {2'b11, b};
  endfunction

  // Drives one poll; returns CE-tick measurements relative to the accept tick.
  task automatic do_poll(input int t, input logic [11:0] b, input logic f3, input bit poke,
                         output int lat, output int blen, output int nv, output int nfall,
                         output bit ok);
    int ce0, guard, rel;
    ptype = t; pbtn = b; FORCE3 = f3; fall_base = falls;
    lat = -1; nv = 0; blen = 0; ok = 0;
    @(negedge CLK); POLL = 1'b1;
    guard = 0;
    while (!BUSY && guard < 100) begin @(negedge CLK); guard++; end
    if (!BUSY) begin POLL = 1'b0; nfall = 0; return; end
    if (!poke) POLL = 1'b0;
    FORCE3 = ~f3;
    ce0 = ce_cnt;
    guard = 0;
    while (BUSY && guard < 20000) begin
      @(negedge CLK); guard++;
      rel = ce_cnt - ce0;
      if (VALID) begin nv++; if (lat < 0) lat = rel; end
      if (poke) POLL = (lat < 0) || (rel >= lat + 100 && rel < lat + 200);
    end
    POLL = 1'b0;
    blen = ce_cnt - ce0;
    nfall = falls - fall_base;
    ok = !BUSY;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    vectors++; if ({PAD_TH, BTN, PRESENT, SIX, VALID, BUSY} !== {1'b1, 12'h0, 4'b0000}) begin
      miscompares++; $display("FAIL reset_vals got %b want %b", {PAD_TH, BTN, PRESENT, SIX, VALID, BUSY}, {1'b1, 16'h0}); end
    #2 RESET = 1'b0;
    repeat (20) @(negedge CLK);
    vectors++; if (BUSY !== 1'b0 || VALID !== 1'b0) begin
      miscompares++; $display("FAIL idle_no_poll got busy=%b valid=%b want 0 0", BUSY, VALID); end
  endtask

  task automatic test_six_button();
    int lat, blen, nv, nfall; bit ok; logic [13:0] e;
    ce_per = 4;
    do_poll(2, 12'h180, 1'b0, 0, lat, blen, nv, nfall, ok);
    e = model(2, 12'h180, 1'b0);
    vectors++; if (!ok) begin miscompares++; $display("FAIL six_done got timeout want poll end"); end
    vectors++; if (nv != 1) begin miscompares++; $display("FAIL six_valid got %0d want 1", nv); end
    vectors++; if (lat != 8 * SETTLE) begin miscompares++; $display("FAIL six_latency got %0d want %0d", lat, 8 * SETTLE); end
    vectors++; if (blen != 8 * SETTLE + GAP) begin miscompares++; $display("FAIL six_busy got %0d want %0d", blen, 8 * SETTLE + GAP); end
    vectors++; if (nfall != 4) begin miscompares++; $display("FAIL six_th_falls got %0d want 4", nfall); end
    vectors++; if ({PRESENT, SIX, BTN} !== e) begin miscompares++; $display("FAIL six_out got %h want %h", {PRESENT, SIX, BTN}, e); end
    vectors++; if (PAD_TH !== 1'b1) begin miscompares++; $display("FAIL six_th_idle got %b want 1", PAD_TH); end
  endtask

  task automatic test_three_button();
    int lat, blen, nv, nfall; bit ok; logic [13:0] e;
    ce_per = 2;
    do_poll(1, 12'h010, 1'b0, 0, lat, blen, nv, nfall, ok);
    e = model(1, 12'h010, 1'b0);
    vectors++; if (!ok || nv != 1) begin miscompares++; $display("FAIL three_valid got ok=%0d nv=%0d want 1 1", ok, nv); end
    vectors++; if ({PRESENT, SIX, BTN} !== e) begin miscompares++; $display("FAIL three_out got %h want %h", {PRESENT, SIX, BTN}, e); end
  endtask

  task automatic test_no_pad();
    int lat, blen, nv, nfall; bit ok;
    do_poll(0, 12'hFFF, 1'b0, 0, lat, blen, nv, nfall, ok);
    vectors++; if (!ok || nv != 1) begin miscompares++; $display("FAIL nopad_valid got ok=%0d nv=%0d want 1 1", ok, nv); end
    vectors++; if ({PRESENT, SIX, BTN} !== 14'h0) begin miscompares++; $display("FAIL nopad_out got %h want 0", {PRESENT, SIX, BTN}); end
  endtask

  task automatic test_force3();
    int lat, blen, nv, nfall; bit ok; logic [13:0] e;
    do_poll(2, 12'h801, 1'b1, 0, lat, blen, nv, nfall, ok);
    e = model(2, 12'h801, 1'b1);
    vectors++; if (!ok || nv != 1) begin miscompares++; $display("FAIL f3_valid got ok=%0d nv=%0d want 1 1", ok, nv); end
    vectors++; if (lat != 2 * SETTLE) begin miscompares++; $display("FAIL f3_latency got %0d want %0d", lat, 2 * SETTLE); end
    vectors++; if (blen != 2 * SETTLE + GAP) begin miscompares++; $display("FAIL f3_busy got %0d want %0d", blen, 2 * SETTLE + GAP); end
    vectors++; if (nfall != 1) begin miscompares++; $display("FAIL f3_th_falls got %0d want 1", nfall); end
    vectors++; if ({PRESENT, SIX, BTN} !== e) begin miscompares++; $display("FAIL f3_out got %h want %h", {PRESENT, SIX, BTN}, e); end
  endtask

  task automatic test_back_to_back();
    int lat, blen, nv, nfall; bit ok; logic [13:0] e; logic [11:0] b;
    b = 12'($urandom);
    do_poll(2, b, 1'b0, 1, lat, blen, nv, nfall, ok);
    e = model(2, b, 1'b0);
    vectors++; if (!ok || nv != 1) begin miscompares++; $display("FAIL b2b_valid got ok=%0d nv=%0d want 1 1", ok, nv); end
    vectors++; if (nfall != 4 || blen != 8 * SETTLE + GAP) begin
      miscompares++; $display("FAIL b2b_ignore got falls=%0d busy=%0d want 4 %0d", nfall, blen, 8 * SETTLE + GAP); end
    vectors++; if ({PRESENT, SIX, BTN} !== e) begin miscompares++; $display("FAIL b2b_out got %h want %h", {PRESENT, SIX, BTN}, e); end
  endtask

  task automatic test_reset_mid_poll();
    int guard, nv, lat, blen, nfall; bit ok; logic [13:0] e; logic [11:0] b;
    b = 12'($urandom) | 12'h001;
    ptype = 2; pbtn = b; FORCE3 = 1'b0; fall_base = falls;
    @(negedge CLK); POLL = 1'b1;
    guard = 0;
    while (!BUSY && guard < 100) begin @(negedge CLK); guard++; end
    POLL = 1'b0;
    guard = 0;
    while (!((falls - fall_base) == 3 && PAD_TH == 1'b0) && guard < 2000) begin @(negedge CLK); guard++; end
    vectors++; if (guard >= 2000) begin miscompares++; $display("FAIL midrst_reach got timeout want phase 5"); end
    #2 RESET = 1'b1;
    #1;
    vectors++; if ({PAD_TH, BTN, PRESENT, SIX, VALID, BUSY} !== {1'b1, 12'h0, 4'b0000}) begin
      miscompares++; $display("FAIL midrst_vals got %b want %b", {PAD_TH, BTN, PRESENT, SIX, VALID, BUSY}, {1'b1, 16'h0}); end
    repeat (3) @(negedge CLK);
    #2 RESET = 1'b0;
    nv = 0;
    repeat (300) begin @(negedge CLK); if (VALID || BUSY) nv++; end
    vectors++; if (nv != 0) begin miscompares++; $display("FAIL midrst_quiet got %0d active cycles want 0", nv); end
    do_poll(2, b, 1'b0, 0, lat, blen, nv, nfall, ok);
    e = model(2, b, 1'b0);
    vectors++; if (!ok || nv != 1 || lat != 8 * SETTLE) begin
      miscompares++; $display("FAIL midrst_clean got ok=%0d nv=%0d lat=%0d want 1 1 %0d", ok, nv, lat, 8 * SETTLE); end
    vectors++; if ({PRESENT, SIX, BTN} !== e) begin miscompares++; $display("FAIL midrst_out got %h want %h", {PRESENT, SIX, BTN}, e); end
  endtask

  task automatic test_random();
    int lat, blen, nv, nfall, t; bit ok; logic f3; logic [13:0] e; logic [11:0] b;
    for (int i = 0; i < 4; i++) begin
      t = $urandom_range(0, 2); b = 12'($urandom); f3 = ($urandom_range(0, 3) == 0);
      ce_rand = (i % 2 == 0);
      do_poll(t, b, f3, 0, lat, blen, nv, nfall, ok);
      e = model(t, b, f3);
      vectors++; if (!ok || nv != 1) begin miscompares++; $display("FAIL rnd%0d_valid got ok=%0d nv=%0d want 1 1", i, ok, nv); end
      vectors++; if (lat != (f3 ? 2 : 8) * SETTLE || blen != lat + GAP) begin
        miscompares++; $display("FAIL rnd%0d_timing got lat=%0d busy=%0d want %0d %0d", i, lat, blen, (f3 ? 2 : 8) * SETTLE, (f3 ? 2 : 8) * SETTLE + GAP); end
      vectors++; if ({PRESENT, SIX, BTN} !== e) begin
        miscompares++; $display("FAIL rnd%0d_out type=%0d f3=%b got %h want %h", i, t, f3, {PRESENT, SIX, BTN}, e); end
    end
    ce_rand = 0;
  endtask

  initial begin
    test_reset();
    test_six_button();
    test_three_button();
    test_no_pad();
    test_force3();
    test_back_to_back();
    test_reset_mid_poll();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog");
  end

endmodule
